// File: rtl/fc_classifier_if.sv
// Bus between the fully-connected classifier and its environment.
// Latency: n/a (wires only).
// Backpressure: none; valid_in is a one-beat qualifier, the classifier always accepts.
//
// Signals:
//   in0..in2   : one pooled feature per channel (signed 12 bit)
//   valid_in   : qualifies in0..in2 for one beat
//   rom_addr   : weight ROM address (current position index)
//   rom_data   : six signed 8-bit weights from a 1-cycle synchronous ROM
//   score0/1   : final class scores (signed ACC_W bit)
//   class_out  : predicted class, 1 = smoking
//   done       : one-cycle pulse when the scores update
//   busy       : a frame is partially accumulated
// The master side is the environment: it feeds features and also hosts the ROM.
interface fc_classifier_if #(
    parameter int ACC_W = 32
);
    logic signed [11:0]      in0;
    logic signed [11:0]      in1;
    logic signed [11:0]      in2;
    logic                    valid_in;
    logic [7:0]              rom_addr;
    logic [47:0]             rom_data;
    logic signed [ACC_W-1:0] score0;
    logic signed [ACC_W-1:0] score1;
    logic                    class_out;
    logic                    done;
    logic                    busy;

    modport master (
        output in0, in1, in2, valid_in, rom_data,
        input  rom_addr, score0, score1, class_out, done, busy
    );

    modport slave (
        input  in0, in1, in2, valid_in, rom_data,
        output rom_addr, score0, score1, class_out, done, busy
    );
endinterface

// File: rtl/fc_classifier.sv
// Two-class fully-connected layer over NUM_POS pooled positions x 3 channels.
// Latency: done pulses 2 cycles after the beat carrying the last position.
// Backpressure: none; every valid_in beat is accepted, gaps of any length are fine.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : fc_classifier_if slave (features in, ROM address/data, scores out)
//
// Pipeline:
//   beat cycle : rom_addr = idx drives the ROM; features and idx are registered
//                into stage 1 at the edge, the ROM registers the weights.
//   stage 1    : weights are on rom_data; the six products are summed per class
//                and folded into the accumulators. On the last position the
//                final sums go straight into the score registers as well.
module fc_classifier #(
    parameter int                      NUM_POS = 169,
    parameter int                      ACC_W   = 32,
    parameter logic signed [ACC_W-1:0] BIAS0   = '0,
    parameter logic signed [ACC_W-1:0] BIAS1   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fc_classifier_if.slave bus
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_POS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]              idx_q;
    logic [7:0]              idx_d;

    logic                    s1_vld_q;
    logic [7:0]              s1_idx_q;
    logic signed [11:0]      s1_in0_q;
    logic signed [11:0]      s1_in1_q;
    logic signed [11:0]      s1_in2_q;

    logic signed [ACC_W-1:0] acc0_q;
    logic signed [ACC_W-1:0] acc1_q;
    logic signed [ACC_W-1:0] acc0_d;
    logic signed [ACC_W-1:0] acc1_d;

    logic signed [ACC_W-1:0] score0_q;
    logic signed [ACC_W-1:0] score1_q;
    logic                    class_q;
    logic                    done_q;

    state_t                  state_q;
    logic                    busy_q;

    // ------------------------------------------------------------------
    // Position counter; the ROM address is the position of the beat now
    // on the inputs, so the weights line up with stage 1 one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        idx_d = idx_q;
        if (bus.valid_in) begin
            idx_d = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
        end
    end

    assign bus.rom_addr = idx_q;

    // ------------------------------------------------------------------
    // Weight unpack: class 0 in the low 24 bits, class 1 in the high 24,
    // channel 0 first within each class.
    // ------------------------------------------------------------------
    logic signed [7:0] w_c0ch0;
    logic signed [7:0] w_c0ch1;
    logic signed [7:0] w_c0ch2;
    logic signed [7:0] w_c1ch0;
    logic signed [7:0] w_c1ch1;
    logic signed [7:0] w_c1ch2;

    assign w_c0ch0 = bus.rom_data[7:0];
    assign w_c0ch1 = bus.rom_data[15:8];
    assign w_c0ch2 = bus.rom_data[23:16];
    assign w_c1ch0 = bus.rom_data[31:24];
    assign w_c1ch1 = bus.rom_data[39:32];
    assign w_c1ch2 = bus.rom_data[47:40];

    // ------------------------------------------------------------------
    // Stage-1 dot products. A 12x8 signed product fits 20 bits and three
    // of them fit 22 bits, so nothing here can overflow.
    // ------------------------------------------------------------------
    logic signed [19:0] m_c0ch0;
    logic signed [19:0] m_c0ch1;
    logic signed [19:0] m_c0ch2;
    logic signed [19:0] m_c1ch0;
    logic signed [19:0] m_c1ch1;
    logic signed [19:0] m_c1ch2;

    assign m_c0ch0 = 20'(s1_in0_q) * 20'(w_c0ch0);
    assign m_c0ch1 = 20'(s1_in1_q) * 20'(w_c0ch1);
    assign m_c0ch2 = 20'(s1_in2_q) * 20'(w_c0ch2);
    assign m_c1ch0 = 20'(s1_in0_q) * 20'(w_c1ch0);
    assign m_c1ch1 = 20'(s1_in1_q) * 20'(w_c1ch1);
    assign m_c1ch2 = 20'(s1_in2_q) * 20'(w_c1ch2);

    logic signed [21:0]      p0_sum;
    logic signed [21:0]      p1_sum;
    logic signed [ACC_W-1:0] p0_ext;
    logic signed [ACC_W-1:0] p1_ext;

    assign p0_sum = 22'(m_c0ch0) + 22'(m_c0ch1) + 22'(m_c0ch2);
    assign p1_sum = 22'(m_c1ch0) + 22'(m_c1ch1) + 22'(m_c1ch2);
    assign p0_ext = ACC_W'(p0_sum);
    assign p1_ext = ACC_W'(p1_sum);

    // ------------------------------------------------------------------
    // Accumulate. Position 0 restarts from the bias instead of the old sum,
    // which lets a new frame follow the previous one with no clear cycle.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] base0;
    logic signed [ACC_W-1:0] base1;
    logic                    final_beat;

    assign base0      = (s1_idx_q == 8'd0) ? BIAS0 : acc0_q;
    assign base1      = (s1_idx_q == 8'd0) ? BIAS1 : acc1_q;
    assign acc0_d     = s1_vld_q ? base0 + p0_ext : acc0_q;
    assign acc1_d     = s1_vld_q ? base1 + p1_ext : acc1_q;
    assign final_beat = s1_vld_q && (s1_idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Registers, including the IDLE/ACCUM FSM that drives busy.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_in0_q <= '0;
            s1_in1_q <= '0;
            s1_in2_q <= '0;
            acc0_q   <= '0;
            acc1_q   <= '0;
            score0_q <= '0;
            score1_q <= '0;
            class_q  <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            s1_vld_q <= bus.valid_in;
            if (bus.valid_in) begin
                s1_idx_q <= idx_q;
                s1_in0_q <= bus.in0;
                s1_in1_q <= bus.in1;
                s1_in2_q <= bus.in2;
            end

            acc0_q <= acc0_d;
            acc1_q <= acc1_d;

            done_q <= final_beat;
            if (final_beat) begin
                score0_q <= acc0_d;
                score1_q <= acc1_d;
                // Strict compare: a tie resolves to class 0.
                class_q  <= (acc1_d > acc0_d);
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.valid_in) begin
                        state_q <= ST_ACCUM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    // A first beat of the next frame arriving on the completion
                    // edge keeps us accumulating without a dip in busy.
                    if (final_beat && !bus.valid_in) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.score0    = score0_q;
    assign bus.score1    = score1_q;
    assign bus.class_out = class_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Bench for fc_classifier: two instances share one stimulus stream, one with
// zero biases and one with BIAS0=5. A posedge process models acceptance and
// pushes expected scores; a negedge process pops them when done pulses and
// checks scores, hold behaviour, busy and rom_addr every cycle.
module tb_fc_classifier;

    localparam int NUM_POS = 169;
    localparam int ACC_W   = 32;
    localparam int B_BIAS0 = 5;

    typedef struct {
        logic signed [ACC_W-1:0] s0a;
        logic signed [ACC_W-1:0] s1a;
        logic                    ca;
        logic signed [ACC_W-1:0] s0b;
        logic signed [ACC_W-1:0] s1b;
        logic                    cb;
        int                      cyc;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               valid_in;
    logic signed [11:0] in0;
    logic signed [11:0] in1;
    logic signed [11:0] in2;

    int          wmode;
    logic [47:0] const_w;
    logic [47:0] seed;

    exp_t        sb[$];
    exp_t        hold;
    int          total;
    int          bad;
    int          cyc;
    int          rst_cnt;
    logic [7:0]  m_idx;
    logic        m_busy;
    bit          mon_en;

    fc_classifier_if #(.ACC_W(ACC_W)) ifa ();
    fc_classifier_if #(.ACC_W(ACC_W)) ifb ();

    assign ifa.in0      = in0;
    assign ifa.in1      = in1;
    assign ifa.in2      = in2;
    assign ifa.valid_in = valid_in;
    assign ifb.in0      = in0;
    assign ifb.in1      = in1;
    assign ifb.in2      = in2;
    assign ifb.valid_in = valid_in;

    fc_classifier #(
        .NUM_POS(NUM_POS), .ACC_W(ACC_W), .BIAS0(32'sd0), .BIAS1(32'sd0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );

    fc_classifier #(
        .NUM_POS(NUM_POS), .ACC_W(ACC_W), .BIAS0(32'sd5), .BIAS1(32'sd0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    // ROM contents: either one word for every address, or an address hash.
    function automatic logic [47:0] rom_word(input logic [7:0] a);
        logic [47:0] w;
        if (wmode == 0) return const_w;
        for (int j = 0; j < 6; j++) begin
            w[j*8 +: 8] = 8'(a * (3 + 2 * j)) ^ seed[j*8 +: 8];
        end
        return w;
    endfunction

    function automatic longint dotk(input int k, input logic signed [11:0] a,
                                    input logic signed [11:0] b, input logic signed [11:0] c,
                                    input logic [47:0] w);
        logic signed [7:0] w0;
        logic signed [7:0] w1;
        logic signed [7:0] w2;
        w0 = w[k*24 +: 8];
        w1 = w[k*24 + 8 +: 8];
        w2 = w[k*24 + 16 +: 8];
        return longint'(a) * longint'(w0) + longint'(b) * longint'(w1) + longint'(c) * longint'(w2);
    endfunction

    always @(posedge clk) ifa.rom_data <= rom_word(ifa.rom_addr);
    always @(posedge clk) ifb.rom_data <= rom_word(ifb.rom_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model of what the classifier accepts at each rising edge.
    task automatic model_loop();
        longint      acc0;
        longint      acc1;
        logic        last_pend;
        logic [47:0] w;
        exp_t        e;
        acc0 = 0;
        acc1 = 0;
        last_pend = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                m_idx = 8'd0;
                m_busy = 1'b0;
                last_pend = 1'b0;
                rst_cnt++;
            end else begin
                m_busy = valid_in ? 1'b1 : (last_pend ? 1'b0 : m_busy);
                last_pend = 1'b0;
                if (valid_in) begin
                    w = rom_word(m_idx);
                    if (m_idx == 8'd0) begin
                        acc0 = 0;
                        acc1 = 0;
                    end
                    acc0 += dotk(0, in0, in1, in2, w);
                    acc1 += dotk(1, in0, in1, in2, w);
                    if (m_idx == 8'(NUM_POS - 1)) begin
                        e.s0a = ACC_W'(acc0);
                        e.s1a = ACC_W'(acc1);
                        e.ca  = acc1 > acc0;
                        e.s0b = ACC_W'(acc0 + B_BIAS0);
                        e.s1b = ACC_W'(acc1);
                        e.cb  = acc1 > (acc0 + B_BIAS0);
                        e.cyc = cyc + 1;
                        sb.push_back(e);
                        last_pend = 1'b1;
                        m_idx = 8'd0;
                    end else begin
                        m_idx = m_idx + 8'd1;
                    end
                end
            end
        end
    endtask

    task automatic monitor_loop();
        logic prev_done;
        int   rst_seen;
        exp_t e;
        prev_done = 1'b0;
        rst_seen = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rst_seen != rst_cnt) begin
                    rst_seen = rst_cnt;
                    hold.s0a = '0; hold.s1a = '0; hold.ca = 1'b0;
                    hold.s0b = '0; hold.s1b = '0; hold.cb = 1'b0;
                end
                if (ifa.done === 1'b1) begin
                    total++;
                    if (prev_done) begin
                        bad++;
                        $display("FAIL done_twice: got done high at cycle %0d and %0d, required single pulse", cyc - 1, cyc);
                    end
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
                    end else begin
                        e = sb.pop_front();
                        if (cyc != e.cyc) begin
                            bad++;
                            $display("FAIL done_latency: got cycle %0d, required cycle %0d", cyc, e.cyc);
                        end
                        hold = e;
                    end
                end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
                    total++;
                    bad++;
                    $display("FAIL missing_done: got no done at cycle %0d, required done", cyc);
                    hold = sb.pop_front();
                end
                total++;
                if (ifb.done !== ifa.done) begin
                    bad++;
                    $display("FAIL done_b: got %0b, required %0b", ifb.done, ifa.done);
                end
                total++;
                if (ifa.score0 !== hold.s0a || ifa.score1 !== hold.s1a || ifa.class_out !== hold.ca) begin
                    bad++;
                    $display("FAIL scores_a: got %0d/%0d/%0b, required %0d/%0d/%0b",
                             ifa.score0, ifa.score1, ifa.class_out, hold.s0a, hold.s1a, hold.ca);
                end
                total++;
                if (ifb.score0 !== hold.s0b || ifb.score1 !== hold.s1b || ifb.class_out !== hold.cb) begin
                    bad++;
                    $display("FAIL scores_b: got %0d/%0d/%0b, required %0d/%0d/%0b",
                             ifb.score0, ifb.score1, ifb.class_out, hold.s0b, hold.s1b, hold.cb);
                end
                total++;
                if (ifa.busy !== m_busy || ifb.busy !== m_busy) begin
                    bad++;
                    $display("FAIL busy: got %0b/%0b, required %0b at cycle %0d", ifa.busy, ifb.busy, m_busy, cyc);
                end
                total++;
                if (ifa.rom_addr !== m_idx || ifb.rom_addr !== m_idx) begin
                    bad++;
                    $display("FAIL rom_addr: got %0d/%0d, required %0d", ifa.rom_addr, ifb.rom_addr, m_idx);
                end
                prev_done = (ifa.done === 1'b1);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_beat(input int kind);
        case (kind)
            0: begin in0 = 12'sd0; in1 = 12'sd0; in2 = 12'sd0; end
            1: begin in0 = 12'sd1; in1 = 12'sd0; in2 = 12'sd0; end
            2: begin in0 = 12'sd2047; in1 = 12'sd2047; in2 = 12'sd2047; end
            default: begin
                in0 = 12'($urandom_range(0, 2047));
                in1 = 12'($urandom_range(0, 2047));
                in2 = 12'($urandom_range(0, 2047));
            end
        endcase
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input int kind, input bit gaps);
        for (int i = 0; i < NUM_POS; i++) begin
            drive_beat(kind);
            if (gaps && i != NUM_POS - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            idle(1);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results, required 0", sb.size());
        end
        idle(1);
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_frame: got %0b, required 0", ifa.busy);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b1;   // must be ignored while in reset
        in0 = 12'sd7; in1 = 12'sd7; in2 = 12'sd7;
        idle(1);
        mon_en = 1'b1;
        idle(2);
        total++;
        if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.class_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got done=%0b busy=%0b class=%0b, required 0/0/0", ifa.done, ifa.busy, ifa.class_out);
        end
        total++;
        if (ifa.score0 !== 32'sd0 || ifa.score1 !== 32'sd0 || ifb.score0 !== 32'sd0) begin
            bad++;
            $display("FAIL reset_scores: got %0d/%0d/%0d, required 0/0/0", ifa.score0, ifa.score1, ifb.score0);
        end
        total++;
        if (ifa.rom_addr !== 8'd0) begin
            bad++;
            $display("FAIL reset_addr: got %0d, required 0", ifa.rom_addr);
        end
        rst_n = 1'b1;
        valid_in = 1'b0;
        idle(2);
        total++;
        if (ifa.rom_addr !== 8'd0 || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got addr=%0d busy=%0b, required 0/0", ifa.rom_addr, ifa.busy);
        end
    endtask

    task automatic test_zeros();
        wmode = 0;
        const_w = {16'($urandom), $urandom};
        run_frame(0, 1'b0);
        drain();
        total++;
        if (ifa.score0 !== 32'sd0 || ifa.score1 !== 32'sd0 || ifa.class_out !== 1'b0) begin
            bad++;
            $display("FAIL zeros: got %0d/%0d/%0b, required 0/0/0", ifa.score0, ifa.score1, ifa.class_out);
        end
    endtask

    task automatic test_pos_class();
        wmode = 0;
        const_w = {8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1};
        run_frame(1, 1'b0);
        drain();
        total++;
        if (ifa.score0 !== 32'sd169 || ifa.score1 !== 32'sd338 || ifa.class_out !== 1'b1) begin
            bad++;
            $display("FAIL pos_class: got %0d/%0d/%0b, required 169/338/1", ifa.score0, ifa.score1, ifa.class_out);
        end
    endtask

    task automatic test_tie();
        longint exp_s;
        wmode = 0;
        const_w = {6{8'h80}};
        exp_s = -longint'(2047) * 128 * 3 * NUM_POS;
        run_frame(2, 1'b0);
        drain();
        total++;
        if (ifa.score0 !== ACC_W'(exp_s) || ifa.score1 !== ACC_W'(exp_s) || ifa.class_out !== 1'b0) begin
            bad++;
            $display("FAIL tie: got %0d/%0d/%0b, required %0d/%0d/0", ifa.score0, ifa.score1, ifa.class_out, exp_s, exp_s);
        end
    endtask

    task automatic test_gaps_back_to_back();
        wmode = 0;
        const_w = {8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1};
        run_frame(1, 1'b1);
        const_w = '0;
        run_frame(1, 1'b0);
        drain();
        total++;
        if (ifb.score0 !== 32'sd5 || ifb.score1 !== 32'sd0 || ifb.class_out !== 1'b0) begin
            bad++;
            $display("FAIL bias_frame: got %0d/%0d/%0b, required 5/0/0", ifb.score0, ifb.score1, ifb.class_out);
        end
    endtask

    task automatic test_reset_midframe();
        wmode = 0;
        const_w = {8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1};
        for (int i = 0; i <= 100; i++) drive_beat(1);
        rst_n = 1'b0;
        valid_in = 1'b1;
        idle(1);
        rst_n = 1'b1;
        valid_in = 1'b0;
        total++;
        if (ifa.rom_addr !== 8'd0 || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL midframe_reset: got addr=%0d busy=%0b, required 0/0", ifa.rom_addr, ifa.busy);
        end
        idle(3);
        run_frame(1, 1'b0);
        drain();
        total++;
        if (ifa.score0 !== 32'sd169 || ifa.score1 !== 32'sd338 || ifa.class_out !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: got %0d/%0d/%0b, required 169/338/1", ifa.score0, ifa.score1, ifa.class_out);
        end
    endtask

    task automatic test_back_to_back();
        wmode = 1;
        seed = {16'($urandom), $urandom};
        run_frame(3, 1'b1);
        run_frame(3, 1'b0);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        wmode = 0;
        const_w = '0;
        seed = '0;
        total = 0;
        bad = 0;
        cyc = 0;
        rst_cnt = 0;
        m_idx = 8'd0;
        m_busy = 1'b0;
        mon_en = 1'b0;
        hold.s0a = '0; hold.s1a = '0; hold.ca = 1'b0;
        hold.s0b = '0; hold.s1b = '0; hold.cb = 1'b0;
        hold.cyc = 0;
        fork
            model_loop();
            monitor_loop();
        join_none

        test_reset();
        test_zeros();
        test_pos_class();
        test_tie();
        test_gaps_back_to_back();
        test_reset_midframe();
        test_back_to_back();

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending results, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
